pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle CPU.
- Owns the PC register and selects the next PC each cycle: PC+4, branch target, jump target or register jump.
- Branch offsets and jump indices are shifted left by 2 here.
- Adds run/halt/fault sequencing, a stall hold, and a retired-instruction counter.
- Sits between the control unit / register file / ALU zero flag and instruction memory.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- TRAP_PC, 32'h00000180, PC loaded when a misaligned register-jump target is detected.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hold PC, state and counter this cycle.
- BranchEq  input  1  beq decoded.
- BranchNe  input  1  bne decoded.
- Zero  input  1  ALU zero flag.
- Jump  input  1  j/jal decoded.
- JumpReg  input  1  jr decoded.
- Halt  input  1  halt instruction decoded.
- Resume  input  1  leave HALTED.
- Imm16  input  16  branch offset, in words.
- JumpIndex  input  26  jump target index.
- RegData  input  32  rs value for jr.
- PC  output  32  current instruction address.
- PCPlus4  output  32  PC+4, combinational.
- Running  output  1  1 only in RUN.
- Fault  output  1  1 for the single cycle spent in FAULT.
- RetiredCount  output  32  count of instructions retired.

Behaviour:
- Reset (async, asserted):
  - PC=RESET_PC, state=BOOT, RetiredCount=0, Running=0, Fault=0.
- States: BOOT, RUN, HALTED, FAULT. State is registered; Running and Fault decode from state.
- BOOT:
  - PC held.
  - Next edge goes to RUN unless Stall=1. One idle cycle after reset release.
- RUN, Stall=0, on each rising edge:
  - An instruction retires: RetiredCount += 1, wrapping 32'hFFFFFFFF -> 0.
  - PC loads the next PC, chosen by the priority list below.
  - Halt=1: state -> HALTED and PC <= PCPlus4. Halt overrides all jump and branch inputs.
  - Otherwise, JumpReg=1 with RegData[1:0]!=0: state -> FAULT, PC unchanged. The instruction still counts as retired.
  - Otherwise state stays RUN.
- Next-PC priority in RUN:
  1. JumpReg: RegData.
  2. Jump: {PCPlus4[31:28], JumpIndex, 2'b00}.
  3. Taken branch: PCPlus4 + ({{14{Imm16[15]}}, Imm16, 2'b00}), modulo 2^32.
     - Taken = (BranchEq & Zero) | (BranchNe & ~Zero).
     - BranchEq and BranchNe both 1 counts as taken, because exactly one condition holds.
  4. Default: PCPlus4.
- Wrap-around:
  - PCPlus4 = PC+4 modulo 2^32, so 32'hFFFFFFFC -> 0.
  - Branch-target addition likewise wraps silently.
- HALTED:
  - PC and RetiredCount held.
  - Resume=1 and Stall=0: -> RUN on the next edge.
  - Halt is ignored while HALTED.
- FAULT:
  - Lasts exactly one cycle. Fault=1, Running=0.
  - Next edge: PC <= TRAP_PC, state -> RUN.
  - Stall does not extend FAULT.
- Stall=1 in BOOT, RUN or HALTED: all registers hold. Stall has priority over Resume.
- Reset asserted mid-operation from any state immediately forces the reset values, without waiting for a clock edge.
- Select inputs are ignored outside RUN.
- All outputs are registered except PCPlus4.

Test Plan:
- Reset pulse, then 3 idle-input cycles -> PC 0 (BOOT), 0, 4, 8; RetiredCount 0, 0, 1, 2; Running goes 1 after BOOT.
- In RUN at PC=32'h00000010, BranchEq=1, Zero=1, Imm16=16'hFFFC -> next PC 32'h00000004.
  - Repeat with Zero=0 -> 32'h00000014.
  - BranchNe=1, Zero=0, Imm16=16'h0003 -> 32'h00000020.
- At PC=32'hA0000008, Jump=1, JumpIndex=26'h0000040 -> PC 32'hA0000100. Jump=1 and JumpReg=1 with RegData=32'h00000400 together -> PC 32'h00000400.
- JumpReg=1, RegData=32'h00000402 -> Fault=1 for one cycle with PC unchanged; next PC 32'h00000180; RetiredCount incremented once; Running returns to 1.
- Halt at PC=32'h0000000C -> PC 32'h00000010 and held, Running=0.
  - Resume with Stall=1 -> stays halted.
  - Resume with Stall=0 -> RUN, then PC 32'h00000014.
- PC=32'hFFFFFFFC with no select -> PC 0. Reset asserted between clock edges mid-RUN -> PC=RESET_PC and RetiredCount=0 immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the control unit / datapath and the PC sequencer.
// The master side drives the decoded selects and operands; the slave side returns the PC and status.
interface pc_sequencer_if;
  logic        Stall;
  logic        BranchEq;
  logic        BranchNe;
  logic        Zero;
  logic        Jump;
  logic        JumpReg;
  logic        Halt;
  logic        Resume;
  logic [15:0] Imm16;
  logic [25:0] JumpIndex;
  logic [31:0] RegData;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Running;
  logic        Fault;
  logic [31:0] RetiredCount;

  modport master (
    output Stall, BranchEq, BranchNe, Zero, Jump, JumpReg, Halt, Resume,
    output Imm16, JumpIndex, RegData,
    input  PC, PCPlus4, Running, Fault, RetiredCount
  );

  modport slave (
    input  Stall, BranchEq, BranchNe, Zero, Jump, JumpReg, Halt, Resume,
    input  Imm16, JumpIndex, RegData,
    output PC, PCPlus4, Running, Fault, RetiredCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, picks the next PC each cycle and
// sequences BOOT/RUN/HALTED/FAULT with a stall hold and a retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] TRAP_PC  = 32'h00000180
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } seqStateT;

  seqStateT    state;
  logic [31:0] pcReg;
  logic [31:0] retiredReg;
  logic        runningReg;
  logic        faultReg;

  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic        branchTaken;
  logic        regMisaligned;
  logic [31:0] nextPc;

  assign pcPlus4       = pcReg + 32'd4;
  assign branchOffset  = {{14{bus.Imm16[15]}}, bus.Imm16, 2'b00};
  // Both beq and bne decoded is always taken: exactly one of the two conditions holds.
  assign branchTaken   = (bus.BranchEq & bus.Zero) | (bus.BranchNe & ~bus.Zero);
  assign regMisaligned = |bus.RegData[1:0];

  always_comb begin
    nextPc = pcPlus4;
    if (bus.JumpReg) begin
      nextPc = bus.RegData;
    end else if (bus.Jump) begin
      nextPc = {pcPlus4[31:28], bus.JumpIndex, 2'b00};
    end else if (branchTaken) begin
      nextPc = pcPlus4 + branchOffset;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= BOOT;
      pcReg      <= RESET_PC;
      retiredReg <= 32'd0;
      runningReg <= 1'b0;
      faultReg   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (!bus.Stall) begin
            state      <= RUN;
            runningReg <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.Stall) begin
            retiredReg <= retiredReg + 32'd1;
            if (bus.Halt) begin
              state      <= HALTED;
              pcReg      <= pcPlus4;
              runningReg <= 1'b0;
            end else if (bus.JumpReg && regMisaligned) begin
              // The offending PC stays visible during the fault cycle.
              state      <= FAULT;
              runningReg <= 1'b0;
              faultReg   <= 1'b1;
            end else begin
              pcReg <= nextPc;
            end
          end
        end
        HALTED: begin
          if (bus.Resume && !bus.Stall) begin
            state      <= RUN;
            runningReg <= 1'b1;
          end
        end
        FAULT: begin
          state      <= RUN;
          pcReg      <= TRAP_PC;
          runningReg <= 1'b1;
          faultReg   <= 1'b0;
        end
        default: begin
          state      <= BOOT;
          runningReg <= 1'b0;
          faultReg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC           = pcReg;
  assign bus.PCPlus4      = pcPlus4;
  assign bus.Running      = runningReg;
  assign bus.Fault        = faultReg;
  assign bus.RetiredCount = retiredReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural
// model of the PC rules (mode / pc / retired count tracked as plain variables).
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam logic [31:0] TRAP_PC  = 32'h00000180;
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic Clk;
  logic Reset;
  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int          total = 0;
  int          bad   = 0;
  int          txn   = 0;
  logic [31:0] mPc;
  logic [31:0] mCnt;
  int          mMode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    bus.Stall = 0; bus.BranchEq = 0; bus.BranchNe = 0; bus.Zero = 0;
    bus.Jump = 0; bus.JumpReg = 0; bus.Halt = 0; bus.Resume = 0;
    bus.Imm16 = '0; bus.JumpIndex = '0; bus.RegData = '0;
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mCnt = 0; mMode = M_BOOT;
  endtask

  // Applies the specification's rules for one rising edge using the present inputs.
  task automatic modelStep();
    logic [31:0] p4;
    int          off;
    p4  = mPc + 32'd4;
    off = int'(signed'(bus.Imm16)) * 4;
    if (mMode == M_FAULT) begin
      mPc = TRAP_PC; mMode = M_RUN;
    end else if (bus.Stall) begin
      // everything holds
    end else if (mMode == M_BOOT) begin
      mMode = M_RUN;
    end else if (mMode == M_HALT) begin
      if (bus.Resume) mMode = M_RUN;
    end else begin
      mCnt = mCnt + 1;
      if (bus.Halt) begin
        mPc = p4; mMode = M_HALT;
      end else if (bus.JumpReg && (bus.RegData % 4 != 0)) begin
        mMode = M_FAULT;
      end else if (bus.JumpReg) begin
        mPc = bus.RegData;
      end else if (bus.Jump) begin
        mPc = (p4 & 32'hF0000000) | (32'(bus.JumpIndex) * 4);
      end else if ((bus.BranchEq && bus.Zero) || (bus.BranchNe && !bus.Zero)) begin
        mPc = p4 + 32'(off);
      end else begin
        mPc = p4;
      end
    end
  endtask

  task automatic checkAll();
    chk("pc", bus.PC, mPc);
    chk("pcplus4", bus.PCPlus4, mPc + 32'd4);
    chk("retired", bus.RetiredCount, mCnt);
    chk("running", {31'd0, bus.Running}, {31'd0, mMode == M_RUN});
    chk("fault", {31'd0, bus.Fault}, {31'd0, mMode == M_FAULT});
  endtask

  task automatic cycle();
    @(posedge Clk);
    modelStep();
    #1;
    checkAll();
    txn++;
    $display("txn %0d pc=%h cnt=%0d run=%b fault=%b", txn, bus.PC, bus.RetiredCount, bus.Running, bus.Fault);
  endtask

  task automatic gotoPc(input logic [31:0] a);
    clearIn();
    bus.JumpReg = 1; bus.RegData = a;
    cycle();
    clearIn();
  endtask

  initial begin
    logic [31:0] cntBefore;
    clearIn();
    modelReset();
    Reset = 1'b1;
    #12;
    chk("reset_pc", bus.PC, RESET_PC);
    chk("reset_cnt", bus.RetiredCount, 32'd0);
    chk("reset_run", {31'd0, bus.Running}, 32'd0);
    chk("reset_fault", {31'd0, bus.Fault}, 32'd0);
    Reset = 1'b0;

    // BOOT idle cycle then sequential fetch
    cycle(); chk("boot_pc", bus.PC, 32'h0);
    cycle(); chk("seq_pc4", bus.PC, 32'h4);
    cycle(); chk("seq_pc8", bus.PC, 32'h8); chk("seq_cnt2", bus.RetiredCount, 32'd2);

    // Branches
    gotoPc(32'h10);
    bus.BranchEq = 1; bus.Zero = 1; bus.Imm16 = 16'hFFFC; cycle();
    chk("beq_taken", bus.PC, 32'h4);
    gotoPc(32'h10);
    bus.BranchEq = 1; bus.Zero = 0; bus.Imm16 = 16'hFFFC; cycle();
    chk("beq_not", bus.PC, 32'h14);
    gotoPc(32'h10);
    bus.BranchNe = 1; bus.Zero = 0; bus.Imm16 = 16'h0003; cycle();
    chk("bne_taken", bus.PC, 32'h20);
    gotoPc(32'h10);
    bus.BranchEq = 1; bus.BranchNe = 1; bus.Zero = 0; bus.Imm16 = 16'h0004; cycle();
    chk("beq_bne_both", bus.PC, 32'h24);

    // Jumps
    gotoPc(32'hA0000008);
    bus.Jump = 1; bus.JumpIndex = 26'h0000040; cycle();
    chk("jump", bus.PC, 32'hA0000100);
    clearIn();
    bus.Jump = 1; bus.JumpIndex = 26'h0000040; bus.JumpReg = 1; bus.RegData = 32'h00000400; cycle();
    chk("jr_over_j", bus.PC, 32'h00000400);

    // Misaligned jr: fault for one cycle (stall must not extend it), then trap
    cntBefore = bus.RetiredCount;
    clearIn();
    bus.JumpReg = 1; bus.RegData = 32'h00000402; cycle();
    chk("fault_flag", {31'd0, bus.Fault}, 32'd1);
    chk("fault_pc", bus.PC, 32'h00000400);
    chk("fault_cnt", bus.RetiredCount, cntBefore + 32'd1);
    clearIn();
    bus.Stall = 1; cycle();
    chk("trap_pc", bus.PC, 32'h00000180);
    chk("trap_run", {31'd0, bus.Running}, 32'd1);
    clearIn();

    // Halt / resume
    gotoPc(32'h0000000C);
    bus.Halt = 1; bus.Jump = 1; bus.JumpIndex = 26'h1234; cycle();
    chk("halt_pc", bus.PC, 32'h10);
    chk("halt_run", {31'd0, bus.Running}, 32'd0);
    clearIn(); bus.Halt = 1; cycle();
    chk("halt_hold", bus.PC, 32'h10);
    clearIn(); bus.Resume = 1; bus.Stall = 1; cycle();
    chk("resume_stalled", {31'd0, bus.Running}, 32'd0);
    clearIn(); bus.Resume = 1; cycle();
    chk("resume_run", {31'd0, bus.Running}, 32'd1);
    chk("resume_pc", bus.PC, 32'h10);
    clearIn(); cycle();
    chk("after_resume", bus.PC, 32'h14);

    // Wrap and stall in RUN
    gotoPc(32'hFFFFFFFC);
    cycle();
    chk("wrap_pc", bus.PC, 32'h0);
    cntBefore = bus.RetiredCount;
    bus.Stall = 1; bus.Jump = 1; bus.JumpIndex = 26'h3; cycle();
    chk("stall_pc", bus.PC, 32'h0);
    chk("stall_cnt", bus.RetiredCount, cntBefore);
    clearIn();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.Stall     = ($urandom_range(0, 4) == 0);
      bus.BranchEq  = $urandom_range(0, 1);
      bus.BranchNe  = $urandom_range(0, 1);
      bus.Zero      = $urandom_range(0, 1);
      bus.Jump      = ($urandom_range(0, 3) == 0);
      bus.JumpReg   = ($urandom_range(0, 4) == 0);
      bus.Halt      = ($urandom_range(0, 9) == 0);
      bus.Resume    = $urandom_range(0, 1);
      bus.Imm16     = 16'($urandom);
      bus.JumpIndex = 26'($urandom);
      bus.RegData   = $urandom;
      if ($urandom_range(0, 3) != 0) bus.RegData[1:0] = 2'b00;
      cycle();
    end
    clearIn();

    // Asynchronous reset between edges while running
    gotoPc(32'h00000040);
    cycle();
    #3 Reset = 1'b1;
    #1;
    chk("async_pc", bus.PC, RESET_PC);
    chk("async_cnt", bus.RetiredCount, 32'd0);
    chk("async_run", {31'd0, bus.Running}, 32'd0);
    #1 Reset = 1'b0;
    modelReset();
    bus.Stall = 1; cycle();
    chk("boot_stall", {31'd0, bus.Running}, 32'd0);
    clearIn(); cycle();
    chk("boot_exit", {31'd0, bus.Running}, 32'd1);
    cycle();
    chk("post_reset_pc", bus.PC, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
